// File: rtl/cache_lru_wb_pkg.sv
// Shared types for the write-back LRU cache.
//   OPCODE_WIDTH : width of the opcode field at the top of each request vector
//   opcode_e     : FLUSH / READ / WRITE / INVAL request opcodes
//   state_e      : controller states (IDLE accepts requests, FLUSH walks the lines)
package cache_lru_wb_pkg;

  localparam int OPCODE_WIDTH = 2;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_FLUSH = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_INVAL = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/cache_age_lru.sv
// True-LRU age tracker and victim picker for a fully-associative cache.
//   clk, rst   : clock and asynchronous active-high reset (ages restart at age[i] = i)
//   touch_i    : make line touchIdx_i the most recently used one at this edge
//   touchIdx_i : index of the line being touched
//   valid_i    : per-line valid bits, used to prefer empty lines as victims
//   victim_o   : lowest-index invalid line, otherwise the line with the oldest age
module cache_age_lru #(
  parameter int ENTRIES = 16,
  parameter int AGE_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               touch_i,
  input  logic [AGE_W-1:0]   touchIdx_i,
  input  logic [ENTRIES-1:0] valid_i,
  output logic [AGE_W-1:0]   victim_o
);

  logic [AGE_W-1:0] age_q [ENTRIES];
  logic [AGE_W-1:0] age_d [ENTRIES];
  logic [AGE_W-1:0] touchAge;
  logic             victimFound;

  // A touch moves the line to age 0 and shifts every younger line one step
  // older, so the ages stay a permutation of 0..ENTRIES-1 at all times.
  always_comb begin
    touchAge = age_q[touchIdx_i];
    for (int i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (touch_i) begin
        if (AGE_W'(i) == touchIdx_i) begin
          age_d[i] = '0;
        end else if (age_q[i] < touchAge) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Empty lines are always cheaper to fill than evicting; only when the cache
  // is full does the oldest line (age ENTRIES-1) get chosen.
  always_comb begin
    victimFound = 1'b0;
    victim_o    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!victimFound && !valid_i[i]) begin
        victim_o    = AGE_W'(i);
        victimFound = 1'b1;
      end
    end
    if (!victimFound) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (age_q[i] == AGE_W'(ENTRIES - 1)) begin
          victim_o = AGE_W'(i);
        end
      end
    end
  end

  // Age registers; reset gives the identity permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        age_q[i] <= AGE_W'(i);
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: rtl/cache_lru_wb.sv
// Write-back, fully-associative cache with true-LRU replacement.
//   clk, rst      : clock and asynchronous active-high reset
//   enable        : global enable; low holds off new requests
//   vector_in     : request {opcode, tag, data}
//   in_valid      : request present; in_ready says it can be taken this cycle
//   data_out      : read data on a READ hit, 0 otherwise (held between strobes)
//   hit_miss_out  : lookup result, qualified by the one-cycle out_valid strobe
//   evict_valid   : one-cycle strobe for a dirty line leaving the cache,
//                   with its tag on tag_out_miss and data on data_out_miss
module cache_lru_wb
  import cache_lru_wb_pkg::*;
#(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ENTRIES    = 16,
  localparam int LINE_WIDTH = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH,
  localparam int AGE_W      = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LINE_WIDTH-1:0] vector_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  hit_miss_out,
  output logic                  out_valid,
  output logic                  evict_valid,
  output logic [TAG_WIDTH-1:0]  tag_out_miss,
  output logic [DATA_WIDTH-1:0] data_out_miss
);

  state_e                state_q, state_d;
  logic [AGE_W-1:0]      ptr_q, ptr_d;
  logic [ENTRIES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]  tag_q  [ENTRIES];
  logic [TAG_WIDTH-1:0]  tag_d  [ENTRIES];
  logic [DATA_WIDTH-1:0] data_q [ENTRIES];
  logic [DATA_WIDTH-1:0] data_d [ENTRIES];

  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  hitMiss_q, hitMiss_d;
  logic                  outValid_q, outValid_d;
  logic                  evictValid_q, evictValid_d;
  logic [TAG_WIDTH-1:0]  evictTag_q, evictTag_d;
  logic [DATA_WIDTH-1:0] evictData_q, evictData_d;

  opcode_e               reqOp;
  logic [TAG_WIDTH-1:0]  reqTag;
  logic [DATA_WIDTH-1:0] reqData;
  logic                  accept;
  logic                  hit;
  logic [AGE_W-1:0]      hitIdx;
  logic                  touch;
  logic [AGE_W-1:0]      touchIdx;
  logic [AGE_W-1:0]      victimIdx;

  assign reqOp    = opcode_e'(vector_in[LINE_WIDTH-1 -: OPCODE_WIDTH]);
  assign reqTag   = vector_in[DATA_WIDTH +: TAG_WIDTH];
  assign reqData  = vector_in[DATA_WIDTH-1:0];
  assign in_ready = enable && !rst && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  assign data_out      = dataOut_q;
  assign hit_miss_out  = hitMiss_q;
  assign out_valid     = outValid_q;
  assign evict_valid   = evictValid_q;
  assign tag_out_miss  = evictTag_q;
  assign data_out_miss = evictData_q;

  cache_age_lru #(
    .ENTRIES (ENTRIES),
    .AGE_W   (AGE_W)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .touch_i    (touch),
    .touchIdx_i (touchIdx),
    .valid_i    (valid_q),
    .victim_o   (victimIdx)
  );

  // Tag lookup across all lines; valid tags are unique, so at most one matches.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == reqTag)) begin
        hit    = 1'b1;
        hitIdx = AGE_W'(i);
      end
    end
  end

  // Next-state logic for the controller, the line arrays and the registered
  // outputs. Everything starts from "hold", strobes start from 0, and each
  // opcode only overrides what it changes. The array state is updated in the
  // same edge as the response so a back-to-back request sees fresh contents.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    dataOut_d    = dataOut_q;
    hitMiss_d    = hitMiss_q;
    outValid_d   = 1'b0;
    evictValid_d = 1'b0;
    evictTag_d   = evictTag_q;
    evictData_d  = evictData_q;
    touch        = 1'b0;
    touchIdx     = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (reqOp)
            OP_FLUSH: begin
              state_d = ST_FLUSH;
              ptr_d   = '0;
            end
            OP_READ: begin
              outValid_d = 1'b1;
              hitMiss_d  = hit;
              dataOut_d  = hit ? data_q[hitIdx] : '0;
              touch      = hit;
              touchIdx   = hitIdx;
            end
            OP_WRITE: begin
              outValid_d = 1'b1;
              hitMiss_d  = hit;
              dataOut_d  = '0;
              if (hit) begin
                data_d[hitIdx]  = reqData;
                dirty_d[hitIdx] = 1'b1;
                touch           = 1'b1;
                touchIdx        = hitIdx;
              end else begin
                if (valid_q[victimIdx] && dirty_q[victimIdx]) begin
                  evictValid_d = 1'b1;
                  evictTag_d   = tag_q[victimIdx];
                  evictData_d  = data_q[victimIdx];
                end
                valid_d[victimIdx] = 1'b1;
                dirty_d[victimIdx] = 1'b1;
                tag_d[victimIdx]   = reqTag;
                data_d[victimIdx]  = reqData;
                touch              = 1'b1;
                touchIdx           = victimIdx;
              end
            end
            OP_INVAL: begin
              outValid_d = 1'b1;
              hitMiss_d  = hit;
              dataOut_d  = '0;
              if (hit) begin
                if (dirty_q[hitIdx]) begin
                  evictValid_d = 1'b1;
                  evictTag_d   = tag_q[hitIdx];
                  evictData_d  = data_q[hitIdx];
                end
                valid_d[hitIdx] = 1'b0;
                dirty_d[hitIdx] = 1'b0;
              end
            end
          endcase
        end
      end
      ST_FLUSH: begin
        if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
          evictValid_d = 1'b1;
          evictTag_d   = tag_q[ptr_q];
          evictData_d  = data_q[ptr_q];
        end
        valid_d[ptr_q] = 1'b0;
        dirty_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == AGE_W'(ENTRIES - 1)) begin
          state_d    = ST_IDLE;
          outValid_d = 1'b1;
          hitMiss_d  = 1'b0;
          dataOut_d  = '0;
        end
      end
    endcase
  end

  // State, line arrays and output registers. Reset aborts any flush in
  // progress and drops unprocessed dirty lines without evicting them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      dataOut_q    <= '0;
      hitMiss_q    <= 1'b0;
      outValid_q   <= 1'b0;
      evictValid_q <= 1'b0;
      evictTag_q   <= '0;
      evictData_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
      dataOut_q    <= dataOut_d;
      hitMiss_q    <= hitMiss_d;
      outValid_q   <= outValid_d;
      evictValid_q <= evictValid_d;
      evictTag_q   <= evictTag_d;
      evictData_q  <= evictData_d;
    end
  end

endmodule

// File: tb/tb_cache_lru_wb.sv
// Testbench for cache_lru_wb: directed scenarios followed by random traffic,
// all compared against a recency-list model of the cache. TAG_WIDTH is 5 so
// that more distinct tags exist than lines and LRU replacement can happen.
`timescale 1ns/1ps
module tb_cache_lru_wb;
  import cache_lru_wb_pkg::*;

  localparam int TW = 5;
  localparam int DW = 8;
  localparam int N  = 16;
  localparam int LW = 2 + TW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [LW-1:0] vector_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          hit_miss_out;
  logic          out_valid;
  logic          evict_valid;
  logic [TW-1:0] tag_out_miss;
  logic [DW-1:0] data_out_miss;

  int checks   = 0;
  int failures = 0;

  // Model: per-slot contents plus a recency list of slot numbers, front = MRU.
  logic          mValid [N];
  logic          mDirty [N];
  logic [TW-1:0] mTag   [N];
  logic [DW-1:0] mData  [N];
  int            lru [$];

  logic          expHit;
  logic [DW-1:0] expData;
  logic          expEvict;
  logic [TW-1:0] expEvTag;
  logic [DW-1:0] expEvData;

  cache_lru_wb #(
    .TAG_WIDTH  (TW),
    .DATA_WIDTH (DW),
    .ENTRIES    (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .vector_in     (vector_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_out      (data_out),
    .hit_miss_out  (hit_miss_out),
    .out_valid     (out_valid),
    .evict_valid   (evict_valid),
    .tag_out_miss  (tag_out_miss),
    .data_out_miss (data_out_miss)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void resetModel();
    lru.delete();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
      mTag[i]   = '0;
      mData[i]  = '0;
      lru.push_back(i);
    end
  endfunction

  function automatic void touchModel(input int s);
    for (int i = 0; i < lru.size(); i++) begin
      if (lru[i] == s) begin
        lru.delete(i);
        break;
      end
    end
    lru.push_front(s);
  endfunction

  function automatic int findSlot(input logic [TW-1:0] tag);
    for (int i = 0; i < N; i++) begin
      if (mValid[i] && mTag[i] == tag) return i;
    end
    return -1;
  endfunction

  // Compute the expected response for one READ/WRITE/INVAL and update the model.
  function automatic void modelAccess(input logic [1:0] op, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    int s;
    int v;
    s        = findSlot(tag);
    expHit   = (s >= 0);
    expData  = '0;
    expEvict = 1'b0;
    if (op == OP_READ) begin
      if (s >= 0) begin
        expData = mData[s];
        touchModel(s);
      end
    end else if (op == OP_WRITE) begin
      if (s >= 0) begin
        mData[s]  = data;
        mDirty[s] = 1'b1;
        touchModel(s);
      end else begin
        v = -1;
        for (int i = 0; i < N; i++) begin
          if (v < 0 && !mValid[i]) v = i;
        end
        if (v < 0) v = lru[lru.size() - 1];
        if (mValid[v] && mDirty[v]) begin
          expEvict  = 1'b1;
          expEvTag  = mTag[v];
          expEvData = mData[v];
        end
        mValid[v] = 1'b1;
        mDirty[v] = 1'b1;
        mTag[v]   = tag;
        mData[v]  = data;
        touchModel(v);
      end
    end else if (op == OP_INVAL) begin
      if (s >= 0) begin
        if (mDirty[s]) begin
          expEvict  = 1'b1;
          expEvTag  = mTag[s];
          expEvData = mData[s];
        end
        mValid[s] = 1'b0;
        mDirty[s] = 1'b0;
      end
    end
  endfunction

  task automatic checkResponse(input logic [1:0] op, input string name);
    checkOutput({name, ".out_valid"}, out_valid, 1);
    checkOutput({name, ".hit"}, hit_miss_out, expHit);
    if (op == OP_READ) checkOutput({name, ".data"}, data_out, expData);
    checkOutput({name, ".evict_valid"}, evict_valid, expEvict);
    if (expEvict) begin
      checkOutput({name, ".evict_tag"}, tag_out_miss, expEvTag);
      checkOutput({name, ".evict_data"}, data_out_miss, expEvData);
    end
  endtask

  // Present one request, wait (bounded) for acceptance, then check the
  // response one cycle after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [TW-1:0] tag, input logic [DW-1:0] data, input string name);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    vector_in = {op, tag, data};
    in_valid  = 1'b1;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput({name, ".accept_timeout"}, in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    modelAccess(op, tag, data);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkResponse(op, name);
  endtask

  // Full flush: evicts in index order, in_ready low for N cycles, out_valid at the end.
  task automatic doFlush(input string name);
    int waitCycles;
    int lowCount;
    int evCount;
    int expEvCount;
    logic expEv;
    waitCycles = 0;
    lowCount   = 0;
    evCount    = 0;
    expEvCount = 0;
    for (int i = 0; i < N; i++) if (mValid[i] && mDirty[i]) expEvCount++;
    @(negedge clk);
    vector_in = {OP_FLUSH, TW'(0), DW'(0)};
    in_valid  = 1'b1;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput({name, ".accept_timeout"}, in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput({name, ".ready_low_start"}, in_ready, 0);
    if (!in_ready) lowCount++;
    for (int j = 0; j < N; j++) begin
      @(posedge clk);
      #1;
      expEv = mValid[j] && mDirty[j];
      checkOutput($sformatf("%s.evict%0d", name, j), evict_valid, expEv);
      if (expEv && evict_valid) begin
        evCount++;
        checkOutput($sformatf("%s.evict_tag%0d", name, j), tag_out_miss, mTag[j]);
        checkOutput($sformatf("%s.evict_data%0d", name, j), data_out_miss, mData[j]);
      end
      checkOutput($sformatf("%s.out_valid%0d", name, j), out_valid, (j == N - 1));
      checkOutput($sformatf("%s.in_ready%0d", name, j), in_ready, (j == N - 1));
      if (j < N - 1 && !in_ready) lowCount++;
      mValid[j] = 1'b0;
      mDirty[j] = 1'b0;
    end
    checkOutput({name, ".ready_low_cycles"}, lowCount, N);
    checkOutput({name, ".evict_count"}, evCount, expEvCount);
    checkOutput({name, ".hit"}, hit_miss_out, 0);
  endtask

  initial begin
    logic [1:0] rop;
    rst       = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    vector_in = '0;
    resetModel();

    // Reset state
    #3;
    checkOutput("reset.in_ready", in_ready, 0);
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.evict_valid", evict_valid, 0);
    checkOutput("reset.data_out", data_out, 0);
    checkOutput("reset.hit", hit_miss_out, 0);
    checkOutput("reset.tag_out_miss", tag_out_miss, 0);
    checkOutput("reset.data_out_miss", data_out_miss, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.in_ready_after", in_ready, 1);

    // Fill and read back
    for (int t = 0; t < N; t++) applyStimulus(OP_WRITE, TW'(t), DW'(8'hFF + t), $sformatf("fill.w%0d", t));
    for (int t = 0; t < N; t++) begin
      applyStimulus(OP_READ, TW'(t), '0, $sformatf("fill.r%0d", t));
      checkOutput($sformatf("fill.rdata%0d", t), data_out, DW'(8'hFF + t));
    end
    applyStimulus(OP_WRITE, TW'(3), 8'h11, "wr3");
    applyStimulus(OP_READ, TW'(3), '0, "rd3");
    checkOutput("rd3.const", data_out, 8'h11);

    // LRU eviction: after touching tag 0, tag 1 is the oldest line
    applyStimulus(OP_READ, TW'(0), '0, "lru.rd0");
    applyStimulus(OP_WRITE, TW'(16), 8'h77, "lru.w16");
    checkOutput("lru.evict_tag_is_1", tag_out_miss, 1);
    checkOutput("lru.evict_data_orig", data_out_miss, 8'h00);

    // Invalidate
    applyStimulus(OP_WRITE, TW'(6), 8'h11, "inval.w6");
    applyStimulus(OP_INVAL, TW'(6), '0, "inval.i6");
    checkOutput("inval.i6.tag", tag_out_miss, 6);
    applyStimulus(OP_READ, TW'(6), '0, "inval.r6");
    applyStimulus(OP_INVAL, TW'(20), '0, "inval.absent");

    // Flush everything, then 5 dirty lines and flush again
    doFlush("flushA");
    for (int t = 0; t < N; t++) applyStimulus(OP_READ, TW'(t), '0, $sformatf("postA.r%0d", t));
    for (int t = 0; t < 5; t++) applyStimulus(OP_WRITE, TW'(t + 8), DW'(8'h40 + t), $sformatf("five.w%0d", t));
    doFlush("flushB");
    for (int t = 0; t < N; t++) applyStimulus(OP_READ, TW'(t + 8), '0, $sformatf("postB.r%0d", t));

    // Reset in the middle of a flush
    for (int t = 0; t < 8; t++) applyStimulus(OP_WRITE, TW'(t), DW'(8'h90 + t), $sformatf("rf.w%0d", t));
    @(negedge clk);
    vector_in = {OP_FLUSH, TW'(0), DW'(0)};
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rf.evict%0d", j), evict_valid, 1);
      checkOutput($sformatf("rf.evict_tag%0d", j), tag_out_miss, mTag[j]);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rf.rst.in_ready", in_ready, 0);
    checkOutput("rf.rst.evict_valid", evict_valid, 0);
    checkOutput("rf.rst.out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rf.after.evict%0d", j), evict_valid, 0);
      checkOutput($sformatf("rf.after.out_valid%0d", j), out_valid, 0);
      checkOutput($sformatf("rf.after.in_ready%0d", j), in_ready, 1);
    end
    for (int t = 0; t < N; t++) applyStimulus(OP_READ, TW'(t), '0, $sformatf("rf.r%0d", t));

    // Handshake: held request with enable low is not taken
    @(negedge clk);
    enable    = 1'b0;
    vector_in = {OP_WRITE, TW'(9), 8'h5C};
    in_valid  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hs.held.out_valid%0d", j), out_valid, 0);
      checkOutput($sformatf("hs.held.in_ready%0d", j), in_ready, 0);
    end
    @(negedge clk);
    enable = 1'b1;
    modelAccess(OP_WRITE, TW'(9), 8'h5C);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkResponse(OP_WRITE, "hs.release");
    applyStimulus(OP_WRITE, TW'(2), 8'hAA, "b2b.w2");
    applyStimulus(OP_READ, TW'(2), '0, "b2b.r2");
    checkOutput("b2b.r2.const", data_out, 8'hAA);
    checkOutput("b2b.r2.hit_const", hit_miss_out, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput($sformatf("rnd%0d.gap.out_valid", n), out_valid, 0);
        enable = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) begin
        doFlush($sformatf("rnd%0d.flush", n));
      end else begin
        rop = 2'($urandom_range(1, 3));
        applyStimulus(rop, TW'($urandom_range(0, 23)), DW'($urandom), $sformatf("rnd%0d", n));
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
